pseudo_spi_rx: RTL and testbench

Receiver that sits directly downstream of the pseudo-SPI SRAM read-out interface. It samples the serial stream (SPI_SO with its two-phase clocks SCLK1/SCLK2 and byte latch LAT) and rebuilds bytes LSB-first. Each byte goes into a small FIFO, and the FIFO drains to a parallel consumer (CPU data port or test capture logic) over a valid/ready handshake. It counts received bytes against a programmed length and flags completion, framing errors and overflow.

---
 rtl/pseudo_spi_rx_pkg.sv | 17 +
 rtl/spi_rx_fifo.sv | 78 +++++++
 rtl/pseudo_spi_rx.sv | 162 ++++++++++++++++
 tb/tb_pseudo_spi_rx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pseudo_spi_rx_pkg.sv
// Shared definitions for the pseudo-SPI receiver: FSM encodings and helpers.
package pseudo_spi_rx_pkg;

    typedef logic [1:0] rx_state_t;

    // Legacy-compatible state encodings shared with the CPU-side defines.
    localparam rx_state_t RX_IDLE  = 2'b00;
    localparam rx_state_t RX_SHIFT = 2'b01;
    localparam rx_state_t RX_WLAT  = 2'b11;
    localparam rx_state_t RX_DONE  = 2'b10;

    // A transfer is in flight while a frame is being shifted or latched.
    function automatic logic rx_is_busy(input rx_state_t st);
        return (st == RX_SHIFT) || (st == RX_WLAT);
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Small synchronous FIFO with a registered head word. Pointers carry an extra
// wrap bit so full and empty are distinguishable without a counter.
module spi_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  push_ok;
    logic                  pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A push into a full FIFO is still accepted when the head leaves this cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = dout_q;

    // Next pointers and next head word; the head is kept in a register so DOUT
    // never depends combinationally on READY.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        dout_d   = dout_q;
        if (pop_ok) begin
            if (rd_ptr_d == wr_ptr_q) begin
                // Last stored entry leaves; the new head can only be this cycle's push.
                if (push_ok) begin
                    dout_d = din;
                end
            end else begin
                dout_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end else if (empty && push_ok) begin
            dout_d = din;
        end
    end

    // Pointer and head registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are valid.
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pseudo_spi_rx.sv
// Pseudo-SPI receiver: samples SPI_SI on SCLK2 rising edges, assembles bytes
// LSB-first, latches them into a FIFO on LAT and tracks transfer progress.
module pseudo_spi_rx
    import pseudo_spi_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BGN,
    input  logic [LEN_WIDTH-1:0]  DATA_LEN,
    input  logic                  SCLK1,
    input  logic                  SCLK2,
    input  logic                  LAT,
    input  logic                  SPI_SI,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  VALID,
    input  logic                  READY,
    output logic [LEN_WIDTH-1:0]  BYTE_CNT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  FRM_ERR,
    output logic                  OVF
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    rx_state_t             state_q, state_d;
    logic                  sclk2_q;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [LEN_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  frm_err_q, frm_err_d;
    logic                  ovf_q, ovf_d;
    logic [LEN_WIDTH-1:0]  byte_cnt_inc;
    logic                  rise;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic                  fifo_full;

    assign rise         = SCLK2 & ~sclk2_q;
    assign pop          = VALID & READY;
    assign byte_cnt_inc = byte_cnt_q + LEN_WIDTH'(1);

    // Receive FSM: shifting, byte latching, error flags and byte counting.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        frm_err_d  = frm_err_q;
        ovf_d      = ovf_q;
        push       = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (BGN) begin
                    len_d      = DATA_LEN;
                    byte_cnt_d = '0;
                    bit_cnt_d  = '0;
                    frm_err_d  = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = (DATA_LEN == '0) ? RX_DONE : RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (!BGN) begin
                    bit_cnt_d = '0;
                    state_d   = RX_IDLE;
                end else if (LAT) begin
                    // Short frame: drop the partial byte and resynchronise.
                    frm_err_d = 1'b1;
                    bit_cnt_d = '0;
                end else if (rise) begin
                    shreg_d   = {SPI_SI, shreg_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (SCLK1) begin
                        frm_err_d = 1'b1;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = RX_WLAT;
                    end
                end
            end
            RX_WLAT: begin
                if (!BGN) begin
                    bit_cnt_d = '0;
                    state_d   = RX_IDLE;
                end else begin
                    // Extra clock after a full byte is a framing error; the bit is dropped.
                    if (rise) begin
                        frm_err_d = 1'b1;
                    end
                    if (LAT) begin
                        push       = 1'b1;
                        byte_cnt_d = byte_cnt_inc;
                        bit_cnt_d  = '0;
                        if (fifo_full && !pop) begin
                            ovf_d = 1'b1;
                        end
                        state_d = (byte_cnt_inc == len_q) ? RX_DONE : RX_SHIFT;
                    end
                end
            end
            default: begin
                if (!BGN) begin
                    state_d = RX_IDLE;
                end
            end
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= RX_IDLE;
            sclk2_q    <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            frm_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk2_q    <= SCLK2;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            frm_err_q  <= frm_err_d;
            ovf_q      <= ovf_d;
        end
    end

    spi_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .din   (shreg_q),
        .pop   (pop),
        .dout  (DOUT),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign VALID    = ~fifo_empty;
    assign BYTE_CNT = byte_cnt_q;
    assign BUSY     = rx_is_busy(state_q);
    assign DONE     = (state_q == RX_DONE);
    assign FRM_ERR  = frm_err_q;
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_pseudo_spi_rx.sv
// Directed self-checking bench for pseudo_spi_rx.
module tb_pseudo_spi_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BGN = 1'b0;
    logic [7:0] DATA_LEN = '0;
    logic       SCLK1 = 1'b0;
    logic       SCLK2 = 1'b0;
    logic       LAT = 1'b0;
    logic       SPI_SI = 1'b0;
    logic       READY = 1'b0;
    logic [7:0] DOUT;
    logic       VALID;
    logic [7:0] BYTE_CNT;
    logic       BUSY;
    logic       DONE;
    logic       FRM_ERR;
    logic       OVF;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] got [$];

    pseudo_spi_rx #(.DATA_WIDTH(8), .LEN_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .BGN(BGN), .DATA_LEN(DATA_LEN),
        .SCLK1(SCLK1), .SCLK2(SCLK2), .LAT(LAT), .SPI_SI(SPI_SI),
        .DOUT(DOUT), .VALID(VALID), .READY(READY), .BYTE_CNT(BYTE_CNT),
        .BUSY(BUSY), .DONE(DONE), .FRM_ERR(FRM_ERR), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    // Handshake signals are stable between edges, so a negedge look shows what the next edge pops.
    always @(negedge CLK) begin
        if (!RST && VALID && READY) got.push_back(DOUT);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Serialise the low nbits of b LSB-first; bit ovl_bit is sent with SCLK1 still high.
    task automatic send_bits(input logic [7:0] b, input int nbits, input int ovl_bit = -1);
        for (int i = 0; i < nbits; i++) begin
            SPI_SI = b[i];
            SCLK1  = 1'b1;
            tick();
            SCLK1  = (i == ovl_bit);
            SCLK2  = 1'b1;
            tick();
            SCLK1  = 1'b0;
            SCLK2  = 1'b0;
        end
    endtask

    task automatic pulse_lat();
        LAT = 1'b1;
        tick();
        LAT = 1'b0;
    endtask

    task automatic start(input logic [7:0] len);
        DATA_LEN = len;
        BGN = 1'b1;
        tick();
    endtask

    task automatic stop();
        BGN = 1'b0;
        tick();
    endtask

    task automatic check_got(input string name, input logic [7:0] exp []);
        n_cmp++;
        if (got.size() != exp.size()) begin
            $display("FAIL %s: popped %0d bytes, expected %0d", name, got.size(), exp.size());
            n_err++;
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                if (got[i] !== exp[i]) begin
                    $display("FAIL %s[%0d]: got %h expected %h", name, i, got[i], exp[i]);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(2);
        n_cmp++;
        if ({DOUT, VALID, BYTE_CNT, BUSY, DONE, FRM_ERR, OVF} !== 22'd0) begin
            $display("FAIL reset_outputs: got %h expected 0",
                     {DOUT, VALID, BYTE_CNT, BUSY, DONE, FRM_ERR, OVF});
            n_err++;
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_zero_len();
        start(8'd0);
        n_cmp++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            $display("FAIL zero_len: DONE=%b BUSY=%b expected DONE=1 BUSY=0", DONE, BUSY);
            n_err++;
        end
        stop();
    endtask

    task automatic test_basic();
        got.delete();
        READY = 1'b1;
        start(8'd3);
        n_cmp++;
        if (BUSY !== 1'b1) begin
            $display("FAIL basic_busy: BUSY=%b expected 1", BUSY);
            n_err++;
        end
        send_bits(8'hAB, 8);
        pulse_lat();
        n_cmp++;
        if (VALID !== 1'b1 || DOUT !== 8'hAB || BYTE_CNT !== 8'd1) begin
            $display("FAIL basic_push_latency: VALID=%b DOUT=%h CNT=%0d expected 1 ab 1", VALID, DOUT, BYTE_CNT);
            n_err++;
        end
        send_bits(8'h3C, 8);
        pulse_lat();
        send_bits(8'h05, 8);
        pulse_lat();
        n_cmp++;
        if (DONE !== 1'b1 || BYTE_CNT !== 8'd3 || BUSY !== 1'b0) begin
            $display("FAIL basic_done: DONE=%b CNT=%0d BUSY=%b expected 1 3 0", DONE, BYTE_CNT, BUSY);
            n_err++;
        end
        tick(3);
        check_got("basic_data", '{8'hAB, 8'h3C, 8'h05});
        n_cmp++;
        if (FRM_ERR !== 1'b0 || OVF !== 1'b0 || VALID !== 1'b0) begin
            $display("FAIL basic_flags: FRM_ERR=%b OVF=%b VALID=%b expected 0 0 0", FRM_ERR, OVF, VALID);
            n_err++;
        end
        stop();
        n_cmp++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            $display("FAIL basic_idle: DONE=%b BUSY=%b expected 0 0", DONE, BUSY);
            n_err++;
        end
    endtask

    task automatic test_overflow();
        got.delete();
        READY = 1'b0;
        start(8'd6);
        for (int i = 1; i <= 6; i++) begin
            send_bits(8'(i), 8);
            pulse_lat();
        end
        n_cmp++;
        if (OVF !== 1'b1 || BYTE_CNT !== 8'd6 || DONE !== 1'b1) begin
            $display("FAIL ovf_flags: OVF=%b CNT=%0d DONE=%b expected 1 6 1", OVF, BYTE_CNT, DONE);
            n_err++;
        end
        n_cmp++;
        if (VALID !== 1'b1 || DOUT !== 8'h01) begin
            $display("FAIL ovf_head: VALID=%b DOUT=%h expected 1 01", VALID, DOUT);
            n_err++;
        end
        READY = 1'b1;
        tick(6);
        check_got("ovf_data", '{8'h01, 8'h02, 8'h03, 8'h04});
        n_cmp++;
        if (VALID !== 1'b0) begin
            $display("FAIL ovf_drained: VALID=%b expected 0", VALID);
            n_err++;
        end
        stop();
    endtask

    task automatic test_full_pop();
        got.delete();
        READY = 1'b0;
        start(8'd5);
        for (int i = 0; i < 4; i++) begin
            send_bits(8'h10 + 8'(i), 8);
            pulse_lat();
        end
        send_bits(8'h14, 8);
        READY = 1'b1;
        pulse_lat();
        n_cmp++;
        if (OVF !== 1'b0 || BYTE_CNT !== 8'd5 || DONE !== 1'b1) begin
            $display("FAIL fullpop_flags: OVF=%b CNT=%0d DONE=%b expected 0 5 1", OVF, BYTE_CNT, DONE);
            n_err++;
        end
        tick(6);
        check_got("fullpop_data", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14});
        stop();
    endtask

    task automatic test_framing();
        got.delete();
        READY = 1'b1;
        start(8'd1);
        send_bits(8'h1F, 5);
        pulse_lat();
        n_cmp++;
        if (FRM_ERR !== 1'b1 || BYTE_CNT !== 8'd0 || VALID !== 1'b0 || BUSY !== 1'b1) begin
            $display("FAIL framing_short: FRM_ERR=%b CNT=%0d VALID=%b BUSY=%b expected 1 0 0 1",
                     FRM_ERR, BYTE_CNT, VALID, BUSY);
            n_err++;
        end
        send_bits(8'hC3, 8);
        pulse_lat();
        n_cmp++;
        if (DONE !== 1'b1 || BYTE_CNT !== 8'd1) begin
            $display("FAIL framing_recover: DONE=%b CNT=%0d expected 1 1", DONE, BYTE_CNT);
            n_err++;
        end
        tick(2);
        check_got("framing_data", '{8'hC3});
        stop();
    endtask

    task automatic test_overlap();
        got.delete();
        READY = 1'b1;
        start(8'd1);
        n_cmp++;
        if (FRM_ERR !== 1'b0) begin
            $display("FAIL overlap_cleared: FRM_ERR=%b expected 0", FRM_ERR);
            n_err++;
        end
        send_bits(8'h5A, 8, 3);
        pulse_lat();
        n_cmp++;
        if (FRM_ERR !== 1'b1 || DONE !== 1'b1) begin
            $display("FAIL overlap_flag: FRM_ERR=%b DONE=%b expected 1 1", FRM_ERR, DONE);
            n_err++;
        end
        tick(2);
        check_got("overlap_data", '{8'h5A});
        stop();
    endtask

    task automatic test_abort();
        got.delete();
        READY = 1'b0;
        start(8'd4);
        send_bits(8'h21, 8);
        pulse_lat();
        send_bits(8'h22, 8);
        pulse_lat();
        send_bits(8'hFF, 4);
        stop();
        n_cmp++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || BYTE_CNT !== 8'd2 || VALID !== 1'b1) begin
            $display("FAIL abort_state: BUSY=%b DONE=%b CNT=%0d VALID=%b expected 0 0 2 1",
                     BUSY, DONE, BYTE_CNT, VALID);
            n_err++;
        end
        READY = 1'b1;
        tick(4);
        check_got("abort_data", '{8'h21, 8'h22});
    endtask

    task automatic test_rst_mid();
        got.delete();
        READY = 1'b0;
        start(8'd2);
        send_bits(8'h77, 8);
        pulse_lat();
        send_bits(8'h0F, 3);
        RST = 1'b1;
        BGN = 1'b0;
        #1;
        n_cmp++;
        if ({DOUT, VALID, BYTE_CNT, BUSY, DONE, FRM_ERR, OVF} !== 22'd0) begin
            $display("FAIL rst_mid_outputs: got %h expected 0",
                     {DOUT, VALID, BYTE_CNT, BUSY, DONE, FRM_ERR, OVF});
            n_err++;
        end
        tick();
        RST = 1'b0;
        READY = 1'b1;
        tick(2);
        n_cmp++;
        if (VALID !== 1'b0 || got.size() != 0) begin
            $display("FAIL rst_mid_empty: VALID=%b popped=%0d expected 0 0", VALID, got.size());
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_basic();
        test_overflow();
        test_full_pop();
        test_framing();
        test_overlap();
        test_abort();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
